// File: rtl/nios_system_video_stream_arbiter.sv
// -----------------------------------------------------------------------------
// nios_system_video_stream_arbiter
//
// Shares one RGB resampler sink between two Avalon-ST video sources. Whole
// packets (frames) are granted round-robin. The granted source is forwarded
// through a 1-deep output register. Beats that arrive outside a packet (valid
// without SOP while idle) are accepted and discarded. An Avalon-MM slave
// exposes the arbiter state and, optionally, packet/drop counters.
//
// Optional feature macro: PKT_COUNT_EN
//   defined   : pkt_cnt0 / pkt_cnt1 / drop_cnt are built (addr1..3)
//   undefined : counters are absent, addr1..3 read 0, writes have no effect
//
// Parameters
//   DW   : data MSB index (stream data width DW+1)
//   EW   : empty MSB index (empty width EW+1)
//   CNTW : counter width, CNTW <= 32 (PKT_COUNT_EN only)
//
// Ports
//   clk, reset_n                  : clock, asynchronous active-low reset
//   stream_in0_* / stream_in1_*   : Avalon-ST sinks (data, empty, sop, eop,
//                                   valid in; ready out)
//   stream_out_*                  : registered Avalon-ST source
//                                   (ready in; data, empty, sop, eop, valid out)
//   slave_address/read/write      : Avalon-MM slave controls
//   slave_writedata               : ignored, any write to addr0 clears counters
//   slave_readdata                : read data, 1-cycle latency, held otherwise
// -----------------------------------------------------------------------------
module nios_system_video_stream_arbiter #(
    parameter int DW   = 15,
    parameter int EW   = 0,
    parameter int CNTW = 32
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic [DW:0]   stream_in0_data,
    input  logic [EW:0]   stream_in0_empty,
    input  logic          stream_in0_startofpacket,
    input  logic          stream_in0_endofpacket,
    input  logic          stream_in0_valid,
    output logic          stream_in0_ready,

    input  logic [DW:0]   stream_in1_data,
    input  logic [EW:0]   stream_in1_empty,
    input  logic          stream_in1_startofpacket,
    input  logic          stream_in1_endofpacket,
    input  logic          stream_in1_valid,
    output logic          stream_in1_ready,

    input  logic          stream_out_ready,
    output logic [DW:0]   stream_out_data,
    output logic [EW:0]   stream_out_empty,
    output logic          stream_out_startofpacket,
    output logic          stream_out_endofpacket,
    output logic          stream_out_valid,

    input  logic [1:0]    slave_address,
    input  logic          slave_read,
    input  logic          slave_write,
    input  logic [31:0]   slave_writedata,
    output logic [31:0]   slave_readdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;     // source that received the most recent grant

    logic   adv;            // output register may load this cycle
    logic   cand0, cand1;   // sources requesting a packet grant
    logic   pick1;          // arbitration result when idle
    logic   acc0, acc1;     // beat accepted for forwarding
    logic   drop0, drop1;   // stray beat discarded while idle
    logic   eop_done0, eop_done1;

    assign adv = stream_out_ready | ~stream_out_valid;

    assign cand0 = stream_in0_valid & stream_in0_startofpacket;
    assign cand1 = stream_in1_valid & stream_in1_startofpacket;
    // On a tie the source that was not granted last wins.
    assign pick1 = cand1 & (~cand0 | ~last_grant);

    // Ready is derived from state, adv and SOP only, never from the same
    // source's valid. While idle a non-SOP beat sees ready=1 and is dropped;
    // a SOP beat sees ready=0 and is granted on this edge instead.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        stream_in0_ready = 1'b0;
        stream_in1_ready = 1'b0;
        unique case (state)
            IDLE: begin
                stream_in0_ready = ~stream_in0_startofpacket;
                stream_in1_ready = ~stream_in1_startofpacket;
            end
            GRANT0:  stream_in0_ready = adv;
            GRANT1:  stream_in1_ready = adv;
            default: ;
        endcase
    end

    assign acc0  = (state == GRANT0) & stream_in0_valid & stream_in0_ready;
    assign acc1  = (state == GRANT1) & stream_in1_valid & stream_in1_ready;
    assign drop0 = (state == IDLE) & stream_in0_valid & stream_in0_ready;
    assign drop1 = (state == IDLE) & stream_in1_valid & stream_in1_ready;
    assign eop_done0 = acc0 & stream_in0_endofpacket;
    assign eop_done1 = acc1 & stream_in1_endofpacket;

    // Arbitration FSM and the 1-deep output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: all sequential state uses non-blocking assignments so
            // every register samples the pre-edge values of the others.
            state                    <= IDLE;
            last_grant               <= 1'b1;
            stream_out_data          <= '0;
            stream_out_empty         <= '0;
            stream_out_startofpacket <= 1'b0;
            stream_out_endofpacket   <= 1'b0;
            stream_out_valid         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cand0 | cand1) begin
                        state      <= pick1 ? GRANT1 : GRANT0;
                        last_grant <= pick1;
                    end
                end
                GRANT0:  if (eop_done0) state <= IDLE;
                GRANT1:  if (eop_done1) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (adv) begin
                stream_out_valid <= ((state == GRANT0) & stream_in0_valid) |
                                    ((state == GRANT1) & stream_in1_valid);
                if (acc0) begin
                    stream_out_data          <= stream_in0_data;
                    stream_out_empty         <= stream_in0_empty;
                    stream_out_startofpacket <= stream_in0_startofpacket;
                    stream_out_endofpacket   <= stream_in0_endofpacket;
                end else if (acc1) begin
                    stream_out_data          <= stream_in1_data;
                    stream_out_empty         <= stream_in1_empty;
                    stream_out_startofpacket <= stream_in1_startofpacket;
                    stream_out_endofpacket   <= stream_in1_endofpacket;
                end
            end
        end
    end

    // Write data carries no information; only the write to addr0 matters.
    logic unused_slave_bits;

`ifdef PKT_COUNT_EN
    logic [CNTW-1:0] pkt_cnt0, pkt_cnt1, drop_cnt;
    logic            cnt_clear;

    assign cnt_clear         = slave_write & (slave_address == 2'd0);
    assign unused_slave_bits = ^slave_writedata;

    // Clear has priority over any increment in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
            drop_cnt <= '0;
        end else if (cnt_clear) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
            drop_cnt <= '0;
        end else begin
            if (eop_done0) pkt_cnt0 <= pkt_cnt0 + 1'b1;
            if (eop_done1) pkt_cnt1 <= pkt_cnt1 + 1'b1;
            // Both sources may drop a stray beat in the same cycle.
            drop_cnt <= drop_cnt + CNTW'(drop0) + CNTW'(drop1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slave_readdata <= '0;
        end else if (slave_read) begin
            unique case (slave_address)
                2'd0:    slave_readdata <= {30'b0, state};
                2'd1:    slave_readdata <= 32'(pkt_cnt0);
                2'd2:    slave_readdata <= 32'(pkt_cnt1);
                default: slave_readdata <= 32'(drop_cnt);
            endcase
        end
    end
`else
    logic [CNTW-1:0] unused_cnt_width;

    assign unused_cnt_width  = '0;
    assign unused_slave_bits = (^slave_writedata) ^ slave_write ^
                               drop0 ^ drop1 ^ eop_done0 ^ eop_done1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slave_readdata <= '0;
        end else if (slave_read) begin
            slave_readdata <= (slave_address == 2'd0) ? {30'b0, state} : 32'h0;
        end
    end
`endif

endmodule
